// File: rtl/inv_facto_if.sv
// rtl/inv_facto_if.sv - start/Done handshake and result bundle for the inverse-factorial engine
//
// Purpose: groups the request (Y, start_i) and result (busy, Done, exact, n_out)
// signals of inv_facto so that they travel as one port.
// Ports (as interface members):
//   Y       [W-1:0]    target value, driven by the requester
//   start_i            start request, driven by the requester
//   busy               computation in progress, driven by the engine
//   Done               one-cycle completion pulse, driven by the engine
//   exact              n_out! == Y, driven by the engine
//   n_out   [N_W-1:0]  largest n with n! <= Y, driven by the engine

interface inv_facto_if #(
  parameter int W   = 8,
  parameter int N_W = 8
);
  logic [W-1:0]   Y;
  logic           start_i;
  logic           busy;
  logic           Done;
  logic           exact;
  logic [N_W-1:0] n_out;

  modport master (
    output Y, start_i,
    input  busy, Done, exact, n_out
  );

  modport slave (
    input  Y, start_i,
    output busy, Done, exact, n_out
  );
endinterface

// File: rtl/inv_facto.sv
// rtl/inv_facto.sv - inverse factorial: largest n with n! <= Y, plus exact-match flag
//
// Purpose: on an accepted start, walks fi = 1!, 2!, 3!, ... one product per clock
// until the running product reaches, passes or would overflow the target.
// Ports:
//   CLK   input   rising-edge system clock
//   RST   input   asynchronous active-low reset
//   bus   slave   Y/start_i request in, busy/Done/exact/n_out result out
//                 (all outputs registered)

module inv_facto #(
  parameter int W   = 8,
  parameter int N_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  inv_facto_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   fi, fi_n;
  logic [N_W-1:0] i, i_n;
  logic [W-1:0]   y_r, y_n;
  logic           exact_r, exact_n;
  logic [N_W-1:0] n_r, n_n;
  logic           busy_r, done_r;

  logic [N_W-1:0]   i_inc;
  logic [W+N_W-1:0] p;

  // Full-width product so overflow can be seen in the upper N_W bits.
  assign i_inc = i + {{(N_W-1){1'b0}}, 1'b1};
  assign p     = {{N_W{1'b0}}, fi} * {{W{1'b0}}, i_inc};

  always_comb begin
    state_n = state;
    fi_n    = fi;
    i_n     = i;
    y_n     = y_r;
    exact_n = exact_r;
    n_n     = n_r;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          y_n     = bus.Y;
          fi_n    = {{(W-1){1'b0}}, 1'b1};
          i_n     = {{(N_W-1){1'b0}}, 1'b1};
          exact_n = 1'b0;
          n_n     = '0;
          state_n = CALC;
        end
      end
      CALC: begin
        if (fi == y_r) begin
          exact_n = 1'b1;
          n_n     = i;
          state_n = DONE;
        end else if (fi > y_r) begin
          // Previous factorial was the last one not exceeding Y.
          exact_n = 1'b0;
          n_n     = i - {{(N_W-1){1'b0}}, 1'b1};
          state_n = DONE;
        end else if (p[W+N_W-1:W] != '0) begin
          // (i+1)! cannot be represented, so it certainly exceeds Y.
          exact_n = 1'b0;
          n_n     = i;
          state_n = DONE;
        end else begin
          fi_n = p[W-1:0];
          i_n  = i_inc;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      fi      <= {{(W-1){1'b0}}, 1'b1};
      i       <= {{(N_W-1){1'b0}}, 1'b1};
      y_r     <= '0;
      exact_r <= 1'b0;
      n_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      fi      <= fi_n;
      i       <= i_n;
      y_r     <= y_n;
      exact_r <= exact_n;
      n_r     <= n_n;
      // Status flags track the next state so they are flops, not decodes.
      busy_r  <= (state_n == CALC);
      done_r  <= (state_n == DONE);
    end
  end

  assign bus.busy  = busy_r;
  assign bus.Done  = done_r;
  assign bus.exact = exact_r;
  assign bus.n_out = n_r;

endmodule
